lsq: RTL and testbench
======================

# lsq

Load/store queue for the merlin32i core. Accepts memory operations from the execute stage, issues them in order on the core data port, tracks up to 2^C_DEPTH_X outstanding accesses, and returns aligned, sign/zero-extended load data to the decoder's register-file write port (lsq_reg_wr/addr/data). It also reports misaligned and bus-error exceptions back to the execute stage.

## Interface
- C_XLEN, 32, data/address width (only 32 supported)
- C_DEPTH_X, 2, log2 of maximum outstanding accesses
- clk_i  in  1  core clock
- clk_en_i  in  1  clock enable; all state and handshakes qualified by it
- resetb_i  in  1  reset; asynchronous, active-low
- exs_valid_i  in  1  execute stage presents an access
- exs_ready_o  out  1  lsq accepts access this cycle
- exs_store_i  in  1  1 = store, 0 = load
- exs_funct3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- exs_addr_i  in  32  effective byte address
- exs_wdata_i  in  32  store data (rs2)
- exs_regd_addr_i  in  5  load destination register
- exs_hpl_i  in  2  hart privilege level
- dreqready_i  in  1  data port accepts request
- dreqvalid_o  out  1  request valid
- dreqhpl_o  out  2  privilege level of request
- dreqaddr_o  out  32  byte address
- dreqwrite_o  out  1  1 = write
- dreqsize_o  out  2  0 byte, 1 half, 2 word
- dreqdata_o  out  32  store data, lane-replicated
- drspready_o  out  1  lsq accepts response
- drspvalid_i  in  1  response valid
- drsprerr_i  in  1  read error
- drspwerr_i  in  1  write error
- drspdata_i  in  32  read data (full word, naturally aligned)
- lsq_reg_wr_o  out  1  register write strobe (to id_stage)
- lsq_reg_addr_o  out  5  register address
- lsq_reg_data_o  out  32  register data
- lsq_excp_o  out  1  exception pulse
- lsq_excp_cause_o  out  4  4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
- lsq_excp_addr_o  out  32  faulting address
- lsq_empty_o  out  1  no access in request register or tracking FIFO

## Operation
- Structure: one request register (feeds data port) plus a tracking FIFO of depth 2^C_DEPTH_X holding {store, funct3, addr[1:0], regd_addr, addr} per outstanding access; occupancy counter counts entries.
- exs_ready_o = (!dreqvalid_o || dreqready_i) && count < 2^C_DEPTH_X, additionally requiring lsq_empty_o for a misaligned access.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0. Accepted misaligned access issues no bus request, enters no FIFO entry; next cycle lsq_excp_o=1, cause 4/6, lsq_excp_addr_o=exs_addr_i.
- Aligned accept: request register loaded; FIFO entry pushed same edge. dreqaddr_o = full byte address; dreqdata_o = SB {4{b}}, SH {2{h}}, SW word.
- Request handshake dreqvalid_o && dreqready_i clears or reloads the request register.
- drspready_o = count != 0. Responses strictly in order; each handshake pops the FIFO head.
- Load, no rerr: next cycle lsq_reg_wr_o=1 unless regd_addr=0; data = drspdata_i byte lane addr[1:0] (LB/LBU), half lane addr[1] (LH/LHU), word (LW); sign-extend LB/LH, zero-extend LBU/LHU.
- Load with rerr: no write; lsq_excp_o, cause 5. Store with werr: cause 7. Store without error: no output. rerr on store / werr on load ignored.
- Legal funct3 guaranteed by execute stage; not checked.

## Timing
- Reset: all registered outputs 0, FIFO empty, count 0; lsq_empty_o=1, exs_ready_o=1, drspready_o=0.
- Accept at edge N -> dreqvalid_o high in cycle N+1. Response handshake at edge M -> lsq_reg_wr_o/lsq_excp_o high cycle M+1 for exactly one cycle.
- Back-to-back: one access per cycle with dreqready_i=1 until FIFO full; full -> exs_ready_o=0 until a pop (no same-cycle pop credit).
- Simultaneous push and pop: count unchanged.
- Response in same cycle as the request handshake for the same access: legal, FIFO entry already present.
- clk_en_i=0: no state change, handshakes ignored, outputs hold.
- Reset mid-operation: outstanding accesses dropped; late responses not accepted (drspready_o=0).

## Test plan
- LW 0x100, rsp 0xDEADBEEF, regd 5 -> dreqaddr_o=0x100 size 2 at N+1; lsq_reg_wr_o=1, addr 5, data 0xDEADBEEF one cycle after response.
- LB/LBU 0x103, rsp 0x80FF_0000 -> data 0xFFFFFF80 / 0x00000080; LH 0x102 -> 0xFFFF80FF.
- SB 0x201 wdata 0x123456AB -> dreqdata_o=0xABABABAB, write=1, size 0; werr response -> excp cause 7 addr 0x201.
- LW 0x102 with 1 access outstanding -> exs_ready_o=0 until empty; then accept, no dreqvalid_o, excp cause 4 addr 0x102.
- dreqready_i=1, drspvalid_i=0, 6 loads offered -> exactly 4 accepted, exs_ready_o low; one response -> one more accepted next cycle; write-back order matches issue order.
- Load to x0 -> no lsq_reg_wr_o; resetb_i low with 3 outstanding -> count 0, drspready_o=0, lsq_empty_o=1 immediately.

Source files
------------

// File: rtl/lsq.sv
// lsq: in-order load/store queue between the execute stage and the core data port.
// Latency: an accepted access drives dreqvalid_o the next cycle. A response produces its register write or exception the next cycle.
// Backpressure: exs_ready_o drops while the request register is stalled or the tracker is full.
//   Misaligned accesses also wait for an empty queue.
// Ports: exs_* access from execute, dreq*/drsp* core data port, lsq_reg_* register-file write-back,
//   lsq_excp_* exception report, lsq_empty_o idle flag. clk_en_i qualifies every state change.
module lsq #(
  parameter int C_XLEN    = 32,
  parameter int C_DEPTH_X = 2
) (
  input  logic              clk_i,
  input  logic              clk_en_i,
  input  logic              resetb_i,
  input  logic              exs_valid_i,
  output logic              exs_ready_o,
  input  logic              exs_store_i,
  input  logic [2:0]        exs_funct3_i,
  input  logic [C_XLEN-1:0] exs_addr_i,
  input  logic [C_XLEN-1:0] exs_wdata_i,
  input  logic [4:0]        exs_regd_addr_i,
  input  logic [1:0]        exs_hpl_i,
  input  logic              dreqready_i,
  output logic              dreqvalid_o,
  output logic [1:0]        dreqhpl_o,
  output logic [C_XLEN-1:0] dreqaddr_o,
  output logic              dreqwrite_o,
  output logic [1:0]        dreqsize_o,
  output logic [C_XLEN-1:0] dreqdata_o,
  output logic              drspready_o,
  input  logic              drspvalid_i,
  input  logic              drsprerr_i,
  input  logic              drspwerr_i,
  input  logic [C_XLEN-1:0] drspdata_i,
  output logic              lsq_reg_wr_o,
  output logic [4:0]        lsq_reg_addr_o,
  output logic [C_XLEN-1:0] lsq_reg_data_o,
  output logic              lsq_excp_o,
  output logic [3:0]        lsq_excp_cause_o,
  output logic [C_XLEN-1:0] lsq_excp_addr_o,
  output logic              lsq_empty_o
);
  localparam int DEPTH = 1 << C_DEPTH_X;

  typedef struct packed {
    logic              store;
    logic [2:0]        funct3;
    logic [4:0]        regd;
    logic [C_XLEN-1:0] addr;
  } entry_t;

  entry_t               fifo_q [DEPTH];
  logic [C_DEPTH_X-1:0] wptr_q, rptr_q;
  logic [C_DEPTH_X:0]   count_q, count_d;

  logic              dreqvalid_q, dreqwrite_q;
  logic [1:0]        dreqhpl_q, dreqsize_q;
  logic [C_XLEN-1:0] dreqaddr_q, dreqdata_q;
  logic              reg_wr_q, excp_q;
  logic [4:0]        reg_addr_q;
  logic [C_XLEN-1:0] reg_data_q, excp_addr_q;
  logic [3:0]        excp_cause_q;

  logic              misal, full, acc, acc_misal, push, pop, rsp_err;
  entry_t            head;
  logic [C_XLEN-1:0] st_data, ld_data;
  logic [7:0]        rb;
  logic [15:0]       rh;

  assign head    = fifo_q[rptr_q];
  // Count can only reach DEPTH through its top bit, so that bit is the full flag.
  assign full    = count_q[C_DEPTH_X];
  assign misal   = ((exs_funct3_i[1:0] == 2'd1) && exs_addr_i[0]) ||
                   ((exs_funct3_i[1:0] == 2'd2) && (exs_addr_i[1:0] != 2'b00));

  assign lsq_empty_o = !dreqvalid_q && (count_q == '0);
  assign exs_ready_o = (!dreqvalid_q || dreqready_i) && !full && (!misal || lsq_empty_o);
  assign drspready_o = (count_q != '0);

  assign acc       = clk_en_i && exs_valid_i && exs_ready_o;
  assign acc_misal = acc && misal;
  assign push      = acc && !misal;
  assign pop       = clk_en_i && drspvalid_i && drspready_o;
  assign rsp_err   = head.store ? drspwerr_i : drsprerr_i;
  assign count_d   = count_q + {{C_DEPTH_X{1'b0}}, push} - {{C_DEPTH_X{1'b0}}, pop};

  // Stores replicate the operand across all lanes so the bus can pick any lane.
  always_comb begin
    st_data = exs_wdata_i;
    case (exs_funct3_i[1:0])
      2'd0:    st_data = {4{exs_wdata_i[7:0]}};
      2'd1:    st_data = {2{exs_wdata_i[15:0]}};
      default: st_data = exs_wdata_i;
    endcase
  end

  // Load lane selection from the word-wide response, then sign/zero extension.
  always_comb begin
    rb      = drspdata_i[{head.addr[1:0], 3'b000} +: 8];
    rh      = drspdata_i[{head.addr[1], 4'b0000} +: 16];
    ld_data = drspdata_i;
    case (head.funct3)
      3'b000:  ld_data = {{24{rb[7]}}, rb};
      3'b001:  ld_data = {{16{rh[15]}}, rh};
      3'b100:  ld_data = {24'b0, rb};
      3'b101:  ld_data = {16'b0, rh};
      default: ld_data = drspdata_i;
    endcase
  end

  // Tracker payload needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= {exs_store_i, exs_funct3_i, exs_regd_addr_i, exs_addr_i};
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dreqvalid_q  <= 1'b0;
      dreqhpl_q    <= '0;
      dreqaddr_q   <= '0;
      dreqwrite_q  <= 1'b0;
      dreqsize_q   <= '0;
      dreqdata_q   <= '0;
      reg_wr_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
      excp_q       <= 1'b0;
      excp_cause_q <= '0;
      excp_addr_q  <= '0;
    end else if (clk_en_i) begin
      if (push) begin
        dreqvalid_q <= 1'b1;
        dreqhpl_q   <= exs_hpl_i;
        dreqaddr_q  <= exs_addr_i;
        dreqwrite_q <= exs_store_i;
        dreqsize_q  <= exs_funct3_i[1:0];
        dreqdata_q  <= st_data;
      end else if (dreqvalid_q && dreqready_i) begin
        dreqvalid_q <= 1'b0;
      end
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;

      reg_wr_q <= pop && !head.store && !rsp_err && (head.regd != 5'd0);
      if (pop && !head.store) begin
        reg_addr_q <= head.regd;
        reg_data_q <= ld_data;
      end
      // A misaligned accept needs an empty queue, so it never coincides with a response.
      excp_q <= acc_misal || (pop && rsp_err);
      if (acc_misal) begin
        excp_cause_q <= exs_store_i ? 4'd6 : 4'd4;
        excp_addr_q  <= exs_addr_i;
      end else if (pop && rsp_err) begin
        excp_cause_q <= head.store ? 4'd7 : 4'd5;
        excp_addr_q  <= head.addr;
      end
    end
  end

  assign dreqvalid_o      = dreqvalid_q;
  assign dreqhpl_o        = dreqhpl_q;
  assign dreqaddr_o       = dreqaddr_q;
  assign dreqwrite_o      = dreqwrite_q;
  assign dreqsize_o       = dreqsize_q;
  assign dreqdata_o       = dreqdata_q;
  assign lsq_reg_wr_o     = reg_wr_q;
  assign lsq_reg_addr_o   = reg_addr_q;
  assign lsq_reg_data_o   = reg_data_q;
  assign lsq_excp_o       = excp_q;
  assign lsq_excp_cause_o = excp_cause_q;
  assign lsq_excp_addr_o  = excp_addr_q;
endmodule

// File: tb/tb_lsq.sv
module tb_lsq;
  logic        clk_i = 1'b0;
  logic        clk_en_i, resetb_i;
  logic        exs_valid_i, exs_ready_o, exs_store_i;
  logic [2:0]  exs_funct3_i;
  logic [31:0] exs_addr_i, exs_wdata_i;
  logic [4:0]  exs_regd_addr_i;
  logic [1:0]  exs_hpl_i;
  logic        dreqready_i, dreqvalid_o, dreqwrite_o;
  logic [1:0]  dreqhpl_o, dreqsize_o;
  logic [31:0] dreqaddr_o, dreqdata_o;
  logic        drspready_o, drspvalid_i, drsprerr_i, drspwerr_i;
  logic [31:0] drspdata_i;
  logic        lsq_reg_wr_o, lsq_excp_o, lsq_empty_o;
  logic [4:0]  lsq_reg_addr_o;
  logic [31:0] lsq_reg_data_o, lsq_excp_addr_o;
  logic [3:0]  lsq_excp_cause_o;

  lsq #(.C_XLEN(32), .C_DEPTH_X(2)) dut (
    .clk_i(clk_i), .clk_en_i(clk_en_i), .resetb_i(resetb_i),
    .exs_valid_i(exs_valid_i), .exs_ready_o(exs_ready_o), .exs_store_i(exs_store_i),
    .exs_funct3_i(exs_funct3_i), .exs_addr_i(exs_addr_i), .exs_wdata_i(exs_wdata_i),
    .exs_regd_addr_i(exs_regd_addr_i), .exs_hpl_i(exs_hpl_i),
    .dreqready_i(dreqready_i), .dreqvalid_o(dreqvalid_o), .dreqhpl_o(dreqhpl_o),
    .dreqaddr_o(dreqaddr_o), .dreqwrite_o(dreqwrite_o), .dreqsize_o(dreqsize_o),
    .dreqdata_o(dreqdata_o), .drspready_o(drspready_o), .drspvalid_i(drspvalid_i),
    .drsprerr_i(drsprerr_i), .drspwerr_i(drspwerr_i), .drspdata_i(drspdata_i),
    .lsq_reg_wr_o(lsq_reg_wr_o), .lsq_reg_addr_o(lsq_reg_addr_o), .lsq_reg_data_o(lsq_reg_data_o),
    .lsq_excp_o(lsq_excp_o), .lsq_excp_cause_o(lsq_excp_cause_o), .lsq_excp_addr_o(lsq_excp_addr_o),
    .lsq_empty_o(lsq_empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit store; bit [2:0] f3; bit [31:0] addr; bit [31:0] wdata; bit [4:0] regd; bit [1:0] hpl;
    bit [31:0] rdata; bit err; bit noise; bit has_exp; bit [31:0] exp_data;
  } op_t;
  typedef struct { bit [1:0] hpl; bit [31:0] addr; bit write; bit [1:0] size; bit [31:0] data; } req_t;
  typedef struct { bit [31:0] rdata; bit rerr; bit werr; bit pulse; } plan_t;
  typedef struct { bit is_exc; bit [4:0] regd; bit [31:0] data; bit [3:0] cause; bit [31:0] addr; } out_t;

  op_t   op_q[$];
  req_t  req_q[$];
  plan_t pend_q[$];
  plan_t iss_q[$];
  out_t  out_q[$];

  int n_cmp = 0, n_bad = 0, accepted = 0;
  int p_valid = 100, p_dready = 100, p_rsp = 100, p_en = 100;
  bit gen_random = 0, en_seen = 0, pulse_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules expressed arithmetically on byte counts and offsets.
  function automatic bit is_misal(input bit [2:0] f3, input bit [31:0] a);
    int nbytes;
    nbytes = 1 << f3[1:0];
    return (a % nbytes) != 0;
  endfunction

  function automatic bit [31:0] load_val(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] w);
    int nbytes, off;
    longint v;
    nbytes = 1 << f3[1:0];
    off = a % 4;
    v = (longint'(w) >> (8 * off)) & ((64'h1 << (8 * nbytes)) - 1);
    if (!f3[2] && nbytes < 4 && v >= (64'h1 << (8 * nbytes - 1))) v = v - (64'h1 << (8 * nbytes));
    return v[31:0];
  endfunction

  function automatic bit [31:0] store_val(input bit [2:0] f3, input bit [31:0] w);
    if (f3[1:0] == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic op_t mk(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                             input bit [4:0] rd, input bit [31:0] rdat, input bit err,
                             input bit he, input bit [31:0] ed);
    op_t o;
    o.store = st; o.f3 = f3; o.addr = a; o.wdata = wd; o.regd = rd; o.hpl = 2'd3;
    o.rdata = rdat; o.err = err; o.noise = 1'b1; o.has_exp = he; o.exp_data = ed;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.store = 1'($urandom_range(1));
    if (o.store) o.f3 = 3'($urandom_range(2));
    else begin
      case ($urandom_range(4))
        0: o.f3 = 3'd0;
        1: o.f3 = 3'd1;
        2: o.f3 = 3'd2;
        3: o.f3 = 3'd4;
        default: o.f3 = 3'd5;
      endcase
    end
    o.addr = 32'h1000 + $urandom_range(255);
    o.wdata = $urandom; o.regd = 5'($urandom_range(31)); o.hpl = 2'($urandom_range(3));
    o.rdata = $urandom; o.err = ($urandom_range(9) == 0); o.noise = 1'($urandom_range(1));
    o.has_exp = 0; o.exp_data = 0;
    return o;
  endfunction

  task automatic drive();
    if (gen_random && op_q.size() == 0) op_q.push_back(rand_op());
    clk_en_i    = ($urandom_range(99) < p_en);
    dreqready_i = ($urandom_range(99) < p_dready);
    if (op_q.size() != 0 && $urandom_range(99) < p_valid) begin
      exs_valid_i = 1; exs_store_i = op_q[0].store; exs_funct3_i = op_q[0].f3;
      exs_addr_i = op_q[0].addr; exs_wdata_i = op_q[0].wdata;
      exs_regd_addr_i = op_q[0].regd; exs_hpl_i = op_q[0].hpl;
    end else begin
      exs_valid_i = 0; exs_store_i = 0; exs_funct3_i = 3'd2; exs_addr_i = 0;
      exs_wdata_i = $urandom; exs_regd_addr_i = 0; exs_hpl_i = 0;
    end
    if (iss_q.size() != 0 && $urandom_range(99) < p_rsp) begin
      drspvalid_i = 1; drspdata_i = iss_q[0].rdata;
      drsprerr_i = iss_q[0].rerr; drspwerr_i = iss_q[0].werr;
    end else begin
      drspvalid_i = 0; drspdata_i = $urandom;
      drsprerr_i = 1'($urandom_range(1)); drspwerr_i = 1'($urandom_range(1));
    end
  endtask

  // Runs at the negedge: checks handshake-level outputs and advances the model
  // for the handshakes that the coming posedge will perform.
  task automatic eval();
    int    m_cnt;
    bit    exp_ready, pulse_next;
    op_t   o;
    req_t  r;
    plan_t p;
    out_t  e;
    m_cnt = req_q.size() + iss_q.size();
    if (en_seen) chk("pulse_timing", 32'(lsq_reg_wr_o | lsq_excp_o), 32'(pulse_exp));
    exp_ready = (req_q.size() == 0 || dreqready_i) && m_cnt < 4 &&
                (!is_misal(exs_funct3_i, exs_addr_i) || m_cnt == 0);
    chk("exs_ready", 32'(exs_ready_o), 32'(exp_ready));
    chk("dreqvalid", 32'(dreqvalid_o), 32'(req_q.size() != 0));
    chk("drspready", 32'(drspready_o), 32'(m_cnt != 0));
    chk("lsq_empty", 32'(lsq_empty_o), 32'(m_cnt == 0));
    if (clk_en_i) begin
      pulse_next = 0;
      if (drspvalid_i && drspready_o && iss_q.size() != 0) begin
        p = iss_q.pop_front();
        pulse_next = p.pulse;
      end
      if (dreqvalid_o && dreqready_i && req_q.size() != 0) begin
        r = req_q.pop_front();
        chk("dreq_addr", dreqaddr_o, r.addr);
        chk("dreq_write", 32'(dreqwrite_o), 32'(r.write));
        chk("dreq_size", 32'(dreqsize_o), 32'(r.size));
        chk("dreq_data", dreqdata_o, r.data);
        chk("dreq_hpl", 32'(dreqhpl_o), 32'(r.hpl));
        iss_q.push_back(pend_q.pop_front());
      end
      if (exs_valid_i && exs_ready_o && op_q.size() != 0) begin
        o = op_q.pop_front();
        accepted++;
        e.is_exc = 0; e.regd = o.regd; e.data = 0; e.cause = 0; e.addr = o.addr;
        if (is_misal(o.f3, o.addr)) begin
          e.is_exc = 1; e.cause = o.store ? 4'd6 : 4'd4;
          out_q.push_back(e);
          pulse_next = 1;
        end else begin
          r.hpl = o.hpl; r.addr = o.addr; r.write = o.store; r.size = o.f3[1:0];
          r.data = (o.store && o.has_exp) ? o.exp_data : store_val(o.f3, o.wdata);
          req_q.push_back(r);
          p.rdata = o.rdata;
          p.rerr  = o.store ? o.noise : o.err;
          p.werr  = o.store ? o.err : o.noise;
          p.pulse = o.err || (!o.store && o.regd != 0);
          pend_q.push_back(p);
          if (o.err) begin
            e.is_exc = 1; e.cause = o.store ? 4'd7 : 4'd5;
            out_q.push_back(e);
          end else if (!o.store && o.regd != 0) begin
            e.data = o.has_exp ? o.exp_data : load_val(o.f3, o.addr, o.rdata);
            out_q.push_back(e);
          end
        end
      end
      pulse_exp = pulse_next;
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
    drive();
    @(negedge clk_i);
    if (resetb_i) eval();
  endtask

  task automatic drain();
    int k;
    k = 0;
    gen_random = 0; p_valid = 100; p_rsp = 100; p_dready = 100; p_en = 100;
    while ((op_q.size() + req_q.size() + iss_q.size() + out_q.size()) != 0 && k < 400) begin
      cycle();
      k++;
    end
    chk("drain_idle", 32'(op_q.size() + req_q.size() + iss_q.size() + out_q.size()), 0);
  endtask

  always @(posedge clk_i) en_seen = clk_en_i && resetb_i;

  // Output monitor: every enabled edge that raises a strobe consumes one expectation.
  always @(negedge clk_i) begin
    out_t e;
    if (resetb_i && en_seen && (lsq_reg_wr_o || lsq_excp_o)) begin
      if (out_q.size() == 0) begin
        chk("unexpected_output", {30'b0, lsq_reg_wr_o, lsq_excp_o}, 0);
      end else begin
        e = out_q.pop_front();
        chk("out_excp", 32'(lsq_excp_o), 32'(e.is_exc));
        chk("out_wr", 32'(lsq_reg_wr_o), 32'(!e.is_exc));
        if (e.is_exc) begin
          chk("excp_cause", 32'(lsq_excp_cause_o), 32'(e.cause));
          chk("excp_addr", lsq_excp_addr_o, e.addr);
        end else begin
          chk("reg_addr", 32'(lsq_reg_addr_o), 32'(e.regd));
          chk("reg_data", lsq_reg_data_o, e.data);
        end
      end
    end
  end

  initial begin
    int base;
    resetb_i = 0; clk_en_i = 1; exs_valid_i = 0; exs_store_i = 0; exs_funct3_i = 3'd2;
    exs_addr_i = 0; exs_wdata_i = 0; exs_regd_addr_i = 0; exs_hpl_i = 0; dreqready_i = 0;
    drspvalid_i = 0; drsprerr_i = 0; drspwerr_i = 0; drspdata_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_dreqvalid", 32'(dreqvalid_o), 0);
    chk("rst_empty", 32'(lsq_empty_o), 1);
    chk("rst_ready", 32'(exs_ready_o), 1);
    chk("rst_drspready", 32'(drspready_o), 0);
    chk("rst_reg_wr", 32'(lsq_reg_wr_o), 0);
    chk("rst_excp", 32'(lsq_excp_o), 0);
    chk("rst_reg_data", lsq_reg_data_o, 0);
    chk("rst_excp_addr", lsq_excp_addr_o, 0);
    resetb_i = 1;

    // Directed accesses with hand-derived results.
    op_q.push_back(mk(0, 3'd2, 32'h100, 0, 5'd5, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF));
    op_q.push_back(mk(0, 3'd0, 32'h103, 0, 5'd6, 32'h80FF0000, 0, 1, 32'hFFFFFF80));
    op_q.push_back(mk(0, 3'd4, 32'h103, 0, 5'd7, 32'h80FF0000, 0, 1, 32'h00000080));
    op_q.push_back(mk(0, 3'd1, 32'h102, 0, 5'd8, 32'h80FF0000, 0, 1, 32'hFFFF80FF));
    op_q.push_back(mk(1, 3'd0, 32'h201, 32'h123456AB, 5'd0, 0, 1, 1, 32'hABABABAB));
    op_q.push_back(mk(0, 3'd2, 32'h102, 0, 5'd9, 0, 0, 0, 0));
    op_q.push_back(mk(0, 3'd2, 32'h104, 0, 5'd0, 32'h55AA55AA, 0, 0, 0));
    op_q.push_back(mk(0, 3'd5, 32'h106, 0, 5'd10, 32'h80010000, 0, 1, 32'h00008001));
    op_q.push_back(mk(1, 3'd1, 32'h20A, 32'h0000BEEF, 5'd0, 0, 0, 1, 32'hBEEFBEEF));
    op_q.push_back(mk(1, 3'd1, 32'h20B, 32'h0000BEEF, 5'd0, 0, 0, 0, 0));
    op_q.push_back(mk(1, 3'd2, 32'h208, 32'hCAFEF00D, 5'd0, 0, 0, 1, 32'hCAFEF00D));
    drain();

    // Fill the tracker with no responses, then free exactly one slot.
    p_rsp = 0;
    for (int i = 0; i < 6; i++) op_q.push_back(mk(0, 3'd2, 32'h300 + 4 * i, 0, 5'(11 + i), $urandom, 0, 0, 0));
    base = accepted;
    repeat (10) cycle();
    chk("fill_accepted", 32'(accepted - base), 4);
    chk("fill_ready_low", 32'(exs_ready_o), 0);
    p_rsp = 100;
    cycle();
    p_rsp = 0;
    repeat (3) cycle();
    chk("one_pop_accepted", 32'(accepted - base), 5);
    drain();

    // Randomized traffic with varying backpressure and clock enable.
    gen_random = 1;
    for (int blk = 0; blk < 15; blk++) begin
      p_valid = $urandom_range(100, 30); p_dready = $urandom_range(100, 20);
      p_rsp = $urandom_range(100, 10); p_en = $urandom_range(100, 60);
      repeat (200) cycle();
    end
    drain();

    // Reset with three accesses outstanding.
    p_rsp = 0;
    for (int i = 0; i < 3; i++) op_q.push_back(mk(0, 3'd2, 32'h400 + 4 * i, 0, 5'(20 + i), $urandom, 0, 0, 0));
    repeat (8) cycle();
    chk("pre_rst_drspready", 32'(drspready_o), 1);
    #2;
    resetb_i = 0;
    drspvalid_i = 1;
    #1;
    chk("mid_rst_drspready", 32'(drspready_o), 0);
    chk("mid_rst_empty", 32'(lsq_empty_o), 1);
    chk("mid_rst_dreqvalid", 32'(dreqvalid_o), 0);
    op_q.delete(); req_q.delete(); pend_q.delete(); iss_q.delete(); out_q.delete();
    pulse_exp = 0;
    @(posedge clk_i);
    #3;
    resetb_i = 1;
    drspvalid_i = 0;
    repeat (3) cycle();
    op_q.push_back(mk(0, 3'd0, 32'h501, 0, 5'd3, 32'h00007F00, 0, 1, 32'h0000007F));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
